pmod_led_scheduler: RTL

- Shares the single 8-LED PMOD between NREQ requesters (debug, status, demo pattern, etc.) using round-robin arbitration with a minimum ownership time.
- Drives the leds input of the existing PMOD LED driver with the current owner's pattern, registered.
- Optional global PWM dimming stage sits on the output.

---
 rtl/pmod_led_pkg.sv | 13 +
 rtl/pmod_led_scheduler_if.sv | 23 ++
 rtl/pmod_led_rr_arb.sv | 31 +++
 rtl/pmod_led_scheduler.sv | 108 ++++++++++
 4 files changed

// File: rtl/pmod_led_pkg.sv
// Shared types and constants for the PMOD LED scheduler.
package pmod_led_pkg;

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    localparam int LED_W           = 8;
    localparam int DUTY_W          = 8;
    localparam int HOLD_CYCLES_DEF = 1000000;

endpackage

// File: rtl/pmod_led_scheduler_if.sv
// Requester-side bundle of the PMOD LED scheduler: requests and patterns in, grant and LEDs out.
interface pmod_led_scheduler_if
    import pmod_led_pkg::*;
#(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*LED_W-1:0] pattern;
    logic [DUTY_W-1:0]     pwm_duty;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [LED_W-1:0]      leds;

    modport master (
        output req, pattern, pwm_duty,
        input  grant, busy, leds
    );

    modport slave (
        input  req, pattern, pwm_duty,
        output grant, busy, leds
    );
endinterface

// File: rtl/pmod_led_rr_arb.sv
// Combinational round-robin search: first requester after ptr (wrapping), optionally skipping ptr itself.
module pmod_led_rr_arb #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             excl_ptr,
    output logic             found,
    output logic [NREQ-1:0]  win_onehot,
    output logic [IDX_W-1:0] win_idx
);
    localparam int unsigned N = NREQ;

    always_comb begin
        logic [IDX_W-1:0] cand;
        found      = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        cand       = '0;
        // ptr itself is the last candidate visited, so it only wins when nobody else asks
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IDX_W'((32'(ptr) + i) % N);
            if (!found && req[cand] && !(excl_ptr && cand == ptr)) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        if (found) win_onehot[win_idx] = 1'b1;
    end
endmodule

// File: rtl/pmod_led_scheduler.sv
// Round-robin owner of the 8-LED PMOD with minimum hold time; optional global
// PWM dimming on the output when PMOD_LED_PWM_EN is defined.
module pmod_led_scheduler
    import pmod_led_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int HOLD_W      = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    pmod_led_scheduler_if.slave  bus
);
    localparam int                IDX_W     = $clog2(NREQ);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  PTR_RST   = IDX_W'(NREQ - 1);

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [NREQ-1:0]   grant_q;
    logic              busy_q;
    logic [LED_W-1:0]  owner_leds;

    logic              found;
    logic [NREQ-1:0]   win_onehot;
    logic [IDX_W-1:0]  win_idx;

    pmod_led_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req        (bus.req),
        .ptr        (ptr),
        .excl_ptr   (state == OWN),
        .found      (found),
        .win_onehot (win_onehot),
        .win_idx    (win_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= PTR_RST;
            hold_cnt   <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            owner_leds <= '0;
        end else begin
            case (state)
                IDLE: begin
                    owner_leds <= '0;
                    if (found) begin
                        state    <= OWN;
                        grant_q  <= win_onehot;
                        busy_q   <= 1'b1;
                        ptr      <= win_idx;
                        hold_cnt <= HOLD_LOAD;
                    end
                end
                OWN: begin
                    // Release and expired-hold preemption share one path; blanking the
                    // LEDs on the grant edge keeps the old pattern off the new grant.
                    if (!bus.req[ptr] || (hold_cnt == '0 && found)) begin
                        owner_leds <= '0;
                        if (found) begin
                            grant_q  <= win_onehot;
                            ptr      <= win_idx;
                            hold_cnt <= HOLD_LOAD;
                        end else begin
                            state   <= IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        owner_leds <= bus.pattern[int'(ptr)*LED_W +: LED_W];
                        if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;

`ifdef PMOD_LED_PWM_EN
    logic [DUTY_W-1:0] pwm_cnt;
    logic [DUTY_W-1:0] duty_q;

    // Duty is only taken at the period wrap so a change never truncates a period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= '0;
            duty_q  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_W'(1);
            if (pwm_cnt == '1) duty_q <= bus.pwm_duty;
        end
    end

    assign bus.leds = owner_leds & {LED_W{pwm_cnt < duty_q}};
`else
    assign bus.leds = owner_leds;
`endif

endmodule
